// File: rtl/wash_pkg.sv
// Shared types and duration table for the wash phase timer.
package wash_pkg;

  localparam int unsigned TICK_DIV_DEFAULT = 1000;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    PAUSE,
    DONE
  } state_t;

  // Phase encoding doubles as the bit index into the enable/timer vectors.
  typedef enum logic [1:0] {
    PH_SOAK  = 2'd0,
    PH_WASH  = 2'd1,
    PH_RINSE = 2'd2,
    PH_SPIN  = 2'd3
  } phase_t;

  typedef enum logic [1:0] {
    MODE1,
    MODE2,
    MODE3
  } mode_t;

  // Duration in ticks for a given mode and phase.
  function automatic logic [7:0] phase_ticks(input mode_t m, input phase_t p);
    logic [7:0] t;
    t = 8'd2;
    case (m)
      MODE2: begin
        case (p)
          PH_WASH: t = 8'd8;
          default: t = 8'd4;
        endcase
      end
      MODE3: begin
        case (p)
          PH_WASH: t = 8'd16;
          PH_SPIN: t = 8'd6;
          default: t = 8'd8;
        endcase
      end
      default: begin
        case (p)
          PH_WASH: t = 8'd4;
          default: t = 8'd2;
        endcase
      end
    endcase
    return t;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk into one-cycle ticks every TICK_DIV cycles while run is high.
module tick_prescaler
  import wash_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

  logic [15:0] count;

  assign tick = run && !clear && (count == LAST);

  // Counter: clear dominates, otherwise advance and wrap while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run) begin
      count <= (count == LAST) ? '0 : count + 16'd1;
    end
  end

endmodule

// File: rtl/wash_phase_timer.sv
// Times the soak/wash/rinse/spin phases requested by the washing controller.
module wash_phase_timer
  import wash_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       soak_en,
  input  logic       wash_en,
  input  logic       rinse_en,
  input  logic       spin_en,
  input  logic       mode1,
  input  logic       mode2,
  input  logic       mode3,
  input  logic       lid,
  input  logic       cancel,
  output logic       timer_soak,
  output logic       timer_wash,
  output logic       timer_rinse,
  output logic       timer_spin,
  output logic [7:0] remaining,
  output logic       busy,
  output logic       err
);

  state_t     state;
  phase_t     phase_q;
  mode_t      mode_q;
  logic [3:0] en_q;
  logic       hist_ok;
  logic [3:0] timer_q;
  logic [7:0] remaining_q;
  logic       busy_q;
  logic       err_q;

  logic [3:0] en;
  logic [3:0] rise;
  logic       multi;
  logic       start;
  logic       active;
  logic       abort;
  logic       tick;
  logic       presc_run;
  logic       presc_clear;
  mode_t      mode_nxt;
  phase_t     start_ph;

  assign en = {spin_en, rinse_en, wash_en, soak_en};

  // Edge/conflict decode and next mode/phase selection.
  always_comb begin
    // hist_ok masks the first cycle after reset so an enable held through
    // reset is not mistaken for a fresh rising edge.
    rise   = en & ~en_q & {4{hist_ok}};
    multi  = (en & (en - 4'd1)) != 4'd0;
    start  = (rise != 4'd0) && ((rise & (rise - 4'd1)) == 4'd0) && !multi;
    active = (state == COUNT) || (state == PAUSE);
    abort  = active && !en[phase_q];

    mode_nxt = mode_q;
    if (rise[0]) begin
      casez ({mode3, mode2, mode1})
        3'b1??:  mode_nxt = MODE3;
        3'b01?:  mode_nxt = MODE2;
        3'b001:  mode_nxt = MODE1;
        default: mode_nxt = MODE1;
      endcase
    end

    case (rise)
      4'b0010: start_ph = PH_WASH;
      4'b0100: start_ph = PH_RINSE;
      4'b1000: start_ph = PH_SPIN;
      default: start_ph = PH_SOAK;
    endcase

    presc_run   = active && !lid;
    presc_clear = cancel || multi || abort || start || !active;
  end

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (presc_run),
    .clear(presc_clear),
    .tick (tick)
  );

  // Phase FSM with registered outputs; cancel > conflict > abort > start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      phase_q     <= PH_SOAK;
      mode_q      <= MODE1;
      en_q        <= '0;
      hist_ok     <= 1'b0;
      timer_q     <= '0;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      en_q    <= en;
      hist_ok <= 1'b1;
      err_q   <= multi;
      if (!cancel && rise[0]) begin
        mode_q <= mode_nxt;
      end

      if (cancel || multi || abort) begin
        state       <= IDLE;
        timer_q     <= '0;
        remaining_q <= '0;
        busy_q      <= 1'b0;
      end else if (start) begin
        state       <= COUNT;
        phase_q     <= start_ph;
        timer_q     <= '0;
        remaining_q <= phase_ticks(mode_nxt, start_ph);
        busy_q      <= 1'b1;
      end else begin
        case (state)
          IDLE: ;
          COUNT, PAUSE: begin
            state <= lid ? PAUSE : COUNT;
            if (tick && (remaining_q != 8'd0)) begin
              remaining_q <= remaining_q - 8'd1;
              if (remaining_q == 8'd1) begin
                state            <= DONE;
                busy_q           <= 1'b0;
                timer_q[phase_q] <= 1'b1;
              end
            end
          end
          DONE: begin
            if (!en[phase_q]) begin
              state   <= IDLE;
              timer_q <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign timer_soak  = timer_q[0];
  assign timer_wash  = timer_q[1];
  assign timer_rinse = timer_q[2];
  assign timer_spin  = timer_q[3];
  assign remaining   = remaining_q;
  assign busy        = busy_q;
  assign err         = err_q;

endmodule

// File: tb/tb_wash_phase_timer.sv
// Directed bench for wash_phase_timer with TICK_DIV=4.
module tb_wash_phase_timer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       soak_en, wash_en, rinse_en, spin_en;
  logic       mode1, mode2, mode3;
  logic       lid, cancel;
  logic       timer_soak, timer_wash, timer_rinse, timer_spin;
  logic [7:0] remaining;
  logic       busy, err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wash_phase_timer #(
    .TICK_DIV(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .soak_en    (soak_en),
    .wash_en    (wash_en),
    .rinse_en   (rinse_en),
    .spin_en    (spin_en),
    .mode1      (mode1),
    .mode2      (mode2),
    .mode3      (mode3),
    .lid        (lid),
    .cancel     (cancel),
    .timer_soak (timer_soak),
    .timer_wash (timer_wash),
    .timer_rinse(timer_rinse),
    .timer_spin (timer_spin),
    .remaining  (remaining),
    .busy       (busy),
    .err        (err)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    soak_en = 0; wash_en = 0; rinse_en = 0; spin_en = 0;
    mode1 = 0; mode2 = 0; mode3 = 0; lid = 0; cancel = 0;
    step(3);
    total++;
    if ({timer_soak, timer_wash, timer_rinse, timer_spin, busy, err} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=000000",
               {timer_soak, timer_wash, timer_rinse, timer_spin, busy, err});
    end
    total++;
    if (remaining !== 8'd0) begin
      bad++;
      $display("FAIL reset_remaining got=%0d want=0", remaining);
    end
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_soak_mode1;
    logic [7:0] exp_rem;
    soak_en = 1;
    step(1);  // edge E
    total++;
    if (remaining !== 8'd2 || busy !== 1'b1) begin
      bad++;
      $display("FAIL soak_load got rem=%0d busy=%b want rem=2 busy=1", remaining, busy);
    end
    for (int k = 1; k <= 8; k++) begin
      step(1);
      exp_rem = 8'(2 - k / 4);
      total++;
      if (remaining !== exp_rem || timer_soak !== (k == 8)) begin
        bad++;
        $display("FAIL soak_E+%0d got rem=%0d timer=%b want rem=%0d timer=%b",
                 k, remaining, timer_soak, exp_rem, (k == 8));
      end
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL soak_busy_done got=%b want=0", busy);
    end
    step(5);
    total++;
    if (timer_soak !== 1'b1) begin
      bad++;
      $display("FAIL soak_hold got=%b want=1", timer_soak);
    end
    soak_en = 0;
    step(1);
    total++;
    if (timer_soak !== 1'b0) begin
      bad++;
      $display("FAIL soak_clear got=%b want=0", timer_soak);
    end
  endtask

  task automatic test_modes;
    logic [7:0] exp_rem;
    // mode2 alone -> soak 4
    mode2 = 1;
    soak_en = 1;
    step(1);
    total++;
    if (remaining !== 8'd4) begin
      bad++;
      $display("FAIL mode2_soak got=%0d want=4", remaining);
    end
    soak_en = 0;
    step(1);
    total++;
    if (remaining !== 8'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL drop_abort got rem=%0d busy=%b want rem=0 busy=0", remaining, busy);
    end
    // mode2|mode3 -> mode3
    mode3 = 1;
    soak_en = 1;
    step(1);
    total++;
    if (remaining !== 8'd8) begin
      bad++;
      $display("FAIL mode3_soak got=%0d want=8", remaining);
    end
    soak_en = 0;
    mode2 = 0; mode3 = 0;
    step(2);
    wash_en = 1;
    step(1);  // edge E
    total++;
    if (remaining !== 8'd16) begin
      bad++;
      $display("FAIL mode3_wash_load got=%0d want=16", remaining);
    end
    for (int k = 1; k <= 64; k++) begin
      step(1);
      exp_rem = 8'(16 - k / 4);
      total++;
      if (remaining !== exp_rem || timer_wash !== (k == 64)) begin
        bad++;
        $display("FAIL wash_E+%0d got rem=%0d timer=%b want rem=%0d timer=%b",
                 k, remaining, timer_wash, exp_rem, (k == 64));
      end
    end
    wash_en = 0;
    step(1);
    total++;
    if (timer_wash !== 1'b0) begin
      bad++;
      $display("FAIL wash_clear got=%b want=0", timer_wash);
    end
  endtask

  task automatic test_lid_pause;
    logic [7:0] exp_rem;
    // relatch mode1
    soak_en = 1;
    step(1);
    soak_en = 0;
    step(2);
    rinse_en = 1;
    step(1);  // edge E
    total++;
    if (remaining !== 8'd2) begin
      bad++;
      $display("FAIL rinse_load got=%0d want=2", remaining);
    end
    step(2);  // E+2
    lid = 1;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      total++;
      if (remaining !== 8'd2 || busy !== 1'b1 || timer_rinse !== 1'b0) begin
        bad++;
        $display("FAIL pause_%0d got rem=%0d busy=%b timer=%b want rem=2 busy=1 timer=0",
                 k, remaining, busy, timer_rinse);
      end
    end
    lid = 0;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      exp_rem = (k < 2) ? 8'd2 : (k < 6) ? 8'd1 : 8'd0;
      total++;
      if (remaining !== exp_rem || timer_rinse !== (k == 6)) begin
        bad++;
        $display("FAIL resume_%0d got rem=%0d timer=%b want rem=%0d timer=%b",
                 k, remaining, timer_rinse, exp_rem, (k == 6));
      end
    end
    rinse_en = 0;
    step(1);
  endtask

  task automatic test_cancel;
    spin_en = 1;
    step(1);
    step(3);
    cancel = 1;
    step(1);
    cancel = 0;
    total++;
    if (remaining !== 8'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL cancel got rem=%0d busy=%b want rem=0 busy=0", remaining, busy);
    end
    for (int k = 1; k <= 12; k++) begin
      step(1);
      total++;
      if (timer_spin !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL cancel_after_%0d got timer=%b busy=%b want 0 0", k, timer_spin, busy);
      end
    end
    spin_en = 0;
    step(1);
  endtask

  task automatic test_back_to_back;
    soak_en = 1; wash_en = 1;
    step(1);
    total++;
    if (err !== 1'b1 || busy !== 1'b0 || remaining !== 8'd0) begin
      bad++;
      $display("FAIL err_set got err=%b busy=%b rem=%0d want 1 0 0", err, busy, remaining);
    end
    soak_en = 0; wash_en = 0;
    step(1);
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL err_clear got=%b want=0", err);
    end
    wash_en = 1;
    step(1);  // edge E, mode1 wash = 4
    total++;
    if (remaining !== 8'd4 || busy !== 1'b1) begin
      bad++;
      $display("FAIL err_wash_load got rem=%0d busy=%b want 4 1", remaining, busy);
    end
    step(15);
    total++;
    if (timer_wash !== 1'b0) begin
      bad++;
      $display("FAIL err_wash_early got=%b want=0", timer_wash);
    end
    step(1);
    total++;
    if (timer_wash !== 1'b1) begin
      bad++;
      $display("FAIL err_wash_done got=%b want=1", timer_wash);
    end
    // swap to rinse from DONE in one edge
    wash_en = 0; rinse_en = 1;
    step(1);
    total++;
    if (timer_wash !== 1'b0 || remaining !== 8'd2 || busy !== 1'b1) begin
      bad++;
      $display("FAIL swap got timer=%b rem=%0d busy=%b want 0 2 1", timer_wash, remaining, busy);
    end
    rinse_en = 0;
    step(1);
  endtask

  task automatic test_reset_mid;
    wash_en = 1;
    step(1);
    step(5);
    rst_n = 0;
    #1;
    total++;
    if (remaining !== 8'd0 || busy !== 1'b0 || err !== 1'b0 ||
        {timer_soak, timer_wash, timer_rinse, timer_spin} !== 4'b0) begin
      bad++;
      $display("FAIL async_reset got rem=%0d busy=%b err=%b", remaining, busy, err);
    end
    step(2);
    rst_n = 1;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      total++;
      if (busy !== 1'b0 || remaining !== 8'd0) begin
        bad++;
        $display("FAIL no_restart_%0d got busy=%b rem=%0d want 0 0", k, busy, remaining);
      end
    end
    wash_en = 0;
    step(1);
    wash_en = 1;
    step(1);
    total++;
    if (busy !== 1'b1 || remaining !== 8'd4) begin
      bad++;
      $display("FAIL restart got busy=%b rem=%0d want 1 4", busy, remaining);
    end
    wash_en = 0;
    step(1);
  endtask

  initial begin
    test_reset();
    test_soak_mode1();
    test_modes();
    test_lid_pause();
    test_cancel();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wash_phase_timer.md
WASH_PHASE_TIMER -- requirements
Module: wash_phase_timer

Interface
REQ-001 Parameter TICK_DIV, default 1000: clk cycles per duration tick; legal range 2..65535.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 soak_en, wash_en, rinse_en, spin_en  input  1 each  phase enables from the washing controller; at most one high at a time.
REQ-005 mode1, mode2, mode3  input  1 each  wash mode selects.
REQ-006 lid  input  1  0 = closed, 1 = open (open pauses counting).
REQ-007 cancel  input  1  abort request.
REQ-008 timer_soak, timer_wash, timer_rinse, timer_spin  output  1 each  phase-complete levels returned to the controller.
REQ-009 remaining  output  8  ticks left in the current phase.
REQ-010 busy  output  1  a phase is loaded and not yet complete.
REQ-011 err  output  1  more than one enable is high.

Function
REQ-012 The FSM SHALL have exactly the states IDLE, COUNT, PAUSE, DONE.
REQ-013 Phase start SHALL be a 0->1 edge of exactly one enable; at that edge: load remaining from the duration table, clear prescaler, busy=1, go to COUNT.
REQ-014 Mode SHALL be captured on the soak_en rising edge only, with priority mode3 > mode2 > mode1; none set selects mode1; the captured mode holds until the next soak_en edge or reset.
REQ-015 Durations in ticks (soak/wash/rinse/spin) SHALL be mode1 2/4/2/2, mode2 4/8/4/4, mode3 8/16/8/6.
REQ-016 In COUNT the prescaler SHALL increment each cycle, wrap at TICK_DIV-1 and emit one tick on wrap; each tick SHALL decrement remaining by 1.
REQ-017 On the edge where remaining reaches 0: go to DONE, busy=0, assert the matching timer_* output; a phase started on edge E SHALL assert timer_* on edge E + duration*TICK_DIV (lid closed throughout).
REQ-018 In DONE the timer_* output SHALL stay high until its enable goes low; it then clears on the next edge and the FSM returns to IDLE.
REQ-019 lid=1 in COUNT SHALL go to PAUSE, freezing prescaler and remaining; lid=0 SHALL return to COUNT and resume from the frozen values.
REQ-020 cancel=1 in any state SHALL, on the next edge, clear all timer_* outputs, remaining, prescaler and busy and return to IDLE; cancel outranks every other event that cycle.
REQ-021 The active enable dropping in COUNT or PAUSE SHALL abort the phase exactly as cancel does.
REQ-022 When more than one enable is high: err=1 that cycle (registered), no load, no decrement, and timer_* outputs cleared; normal operation resumes once a single enable is high, starting only on a fresh rising edge.
REQ-023 A rising edge of a different enable while in DONE SHALL clear the old timer_* output and start the new phase on the same edge.
REQ-024 remaining SHALL never wrap below 0.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, remaining=0, prescaler=0, captured mode=mode1, all timer_*=0, busy=0, err=0 and the enable-edge history registers to 0.
REQ-027 Reset asserted mid-phase SHALL discard the phase; after release no phase starts until a fresh enable rising edge.

Structure
REQ-028 The shared package wash_pkg SHALL hold the phase/state typedefs, the mode-by-phase duration table and the TICK_DIV default.
REQ-029 The prescaler SHALL be a sub-module tick_prescaler (inputs run and clear; output tick).

Verification (TICK_DIV=4)
REQ-030 mode1 latched, soak_en rises at edge E, lid=0 -> timer_soak high at E+8, remaining steps 2,1,0, and timer_soak stays high until soak_en falls.
REQ-031 mode2|mode3 both high at the soak_en edge, then wash_en -> mode3 is used and timer_wash rises 64 cycles after the wash_en edge.
REQ-032 lid=1 for 10 cycles mid-rinse (mode1) -> remaining frozen during the pause; timer_rinse at E+8+10.
REQ-033 cancel pulsed 3 cycles into spin -> next edge: remaining=0, busy=0, IDLE; timer_spin never asserts.
REQ-034 soak_en and wash_en high together -> err=1, no load; both dropped, then wash_en rises alone -> normal wash timing.
REQ-035 rst_n low mid-wash -> all outputs 0 immediately; wash_en still high after release -> no restart until wash_en toggles.
